// File: rtl/cache_fill_fsm.sv
// Block fill on cache miss: issues one word read per cycle from the cycle after the miss and writes each returned word into the data array.
// The tag write and fill_done pulse on the last returned word. There is no backpressure: memory_data_valid alone paces the receive side.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH      = 16,
    parameter int WORDS_PER_BLOCK = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  miss_detected,
    input  logic [ADDR_WIDTH-1:0] miss_address,
    output logic                  fsm_busy,
    output logic                  memory_en,
    output logic [ADDR_WIDTH-1:0] memory_address,
    input  logic                  memory_data_valid,
    input  logic [15:0]           memory_data,
    output logic                  write_data_array,
    output logic [ADDR_WIDTH-1:0] fill_address,
    output logic [15:0]           fill_data,
    output logic                  write_tag_array,
    output logic                  fill_done
);

    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W = OFF_W + 1;

    localparam logic [CNT_W-1:0]      WPB_C     = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0]      LAST_C    = CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK  = ADDR_WIDTH'(2 * WORDS_PER_BLOCK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]      recv_cnt_q, recv_cnt_d;

    // Word offset replaces address bits [OFF_W:1]; base has those bits clear, so OR never carries.
    function automatic logic [ADDR_WIDTH-1:0] word_off(input logic [CNT_W-1:0] cnt);
        return {{(ADDR_WIDTH-OFF_W-1){1'b0}}, cnt[OFF_W-1:0], 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        issue_cnt_d      = issue_cnt_q;
        recv_cnt_d       = recv_cnt_q;
        fsm_busy         = 1'b0;
        memory_en        = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_address     = '0;
        fill_data        = memory_data;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                fsm_busy = miss_detected;
                if (miss_detected) begin
                    base_d      = miss_address & ~BLK_MASK;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    state_d     = FILL;
                end
            end

            FILL: begin
                fsm_busy = 1'b1;
                if (issue_cnt_q < WPB_C) begin
                    memory_en      = 1'b1;
                    memory_address = base_q | word_off(issue_cnt_q);
                    issue_cnt_d    = issue_cnt_q + 1'b1;
                end
                // Returns may land in the same cycle as their request; only valid drives receive.
                if (memory_data_valid && (recv_cnt_q < WPB_C)) begin
                    write_data_array = 1'b1;
                    fill_address     = base_q | word_off(recv_cnt_q);
                    recv_cnt_d       = recv_cnt_q + 1'b1;
                    if (recv_cnt_q == LAST_C) begin
                        write_tag_array = 1'b1;
                        fill_done       = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
